i2c_txn_arbiter: RTL and testbench

Round-robin scheduler that shares one byte-level I2C master engine between NUM_REQ requesters. It latches the winning request, issues a single-byte command to the master, waits for completion, and returns status and read data to the winner. It includes a watchdog that aborts stuck transactions. It sits between the system-side requester ports and the I2C master's command interface.

---
 rtl/i2c_txn_arbiter.sv | 174 +++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine between
// NUM_REQ requesters. It latches the winner's command, strobes the master,
// waits for completion under a watchdog, and returns status and read data.
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TW          = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [1:0]           status,
    output logic [7:0]           rdata,
    output logic                 m_start,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_wdata,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    cmd_t                 cmd_q, cmd_d;
    logic [TW-1:0]        wd_q, wd_d;
    logic [1:0]           status_q, status_d;
    logic [7:0]           rdata_q, rdata_d;

    cmd_t [NUM_REQ-1:0]   req_cmd;
    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic                 wd_expired;

    // Repack the flat per-requester buses into one command struct per lane.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign req_cmd[gi] = '{rw:    req_rw[gi],
                               addr:  req_addr[7*gi +: 7],
                               wdata: req_wdata[8*gi +: 8]};
    end

    assign wd_expired = (wd_q == TW'(TIMEOUT_CYC - 1));

    // Round-robin pick: first requester at or above rr_ptr, wrapping. The scan
    // runs from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        logic [IW:0] sum;
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            if (req[sum[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = sum[IW-1:0];
            end
        end
    end

    // State and datapath registers; reset is asynchronous so every output
    // collapses to zero as soon as reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            cmd_q    <= '0;
            wd_q     <= '0;
            status_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            cmd_q    <= cmd_d;
            wd_q     <= wd_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic; m_done beats the watchdog when both land together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld && !m_busy) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (m_done || wd_expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: latch the winner, run the watchdog, capture results.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        cmd_d    = cmd_q;
        wd_d     = wd_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && !m_busy) begin
                    gidx_d           = pick_idx;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    cmd_d            = req_cmd[pick_idx];
                end
            end
            ISSUE: begin
                wd_d = '0;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (m_done) begin
                    status_d = m_nack ? ST_NACK : ST_OK;
                    rdata_d  = m_rdata;
                end else if (wd_expired) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = '0;
                end
            end
            RESP: begin
                gnt_d    = '0;
                rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs: strobes decode from state, everything else is registered.
    always_comb begin
        m_start = (state_q == ISSUE);
        m_abort = (state_q == WAIT) && wd_expired && !m_done;
        done    = (state_q == RESP) ? gnt_q : '0;
        gnt     = gnt_q;
        status  = status_q;
        rdata   = rdata_q;
        m_rw    = cmd_q.rw;
        m_addr  = cmd_q.addr;
        m_wdata = cmd_q.wdata;
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: a scripted master answers each command,
// expected responses are queued at request time and checked when done fires.
module tb_i2c_txn_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req, req_rw;
    logic [7*NR-1:0] req_addr;
    logic [8*NR-1:0] req_wdata;
    logic [NR-1:0] gnt, done;
    logic [1:0]    status;
    logic [7:0]    rdata;
    logic          m_start, m_rw, m_abort;
    logic [6:0]    m_addr;
    logic [7:0]    m_wdata;
    logic          m_busy, m_done, m_nack;
    logic [7:0]    m_rdata;

    typedef struct {
        int         idx;
        logic [1:0] status;
        logic [7:0] rdata;
        logic       chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    i2c_txn_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(16), .TW(5)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .status(status), .rdata(rdata), .m_start(m_start), .m_rw(m_rw),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_abort(m_abort),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ri, input logic rw, input logic [6:0] a, input logic [7:0] wd);
        req       = req | onehot(ri);
        req_rw    = rw ? (req_rw | onehot(ri)) : (req_rw & ~onehot(ri));
        req_addr  = (req_addr & ~(28'h7F << (7*ri))) | ({21'b0, a} << (7*ri));
        req_wdata = (req_wdata & ~(32'hFF << (8*ri))) | ({24'b0, wd} << (8*ri));
    endtask

    task automatic push_exp(input int ri, input logic [1:0] st, input logic [7:0] rd, input logic crd);
        exp_t e;
        e.idx = ri; e.status = st; e.rdata = rd; e.chk_rdata = crd;
        sb.push_back(e);
    endtask

    // Called in the cycle the done pulse is due.
    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_done"}, done, onehot(e.idx));
        chk({tag, "_status"}, status, e.status);
        if (e.chk_rdata) chk({tag, "_rdata"}, rdata, e.rdata);
    endtask

    // One isolated transaction: master answers dly cycles after m_start.
    task automatic txn(input string tag, input int ri, input logic rw, input logic [6:0] a,
                       input logic [7:0] wd, input int dly, input logic nk, input logic [7:0] rd);
        req = '0;
        set_req(ri, rw, a, wd);
        push_exp(ri, nk ? 2'b01 : 2'b00, rd, rw && !nk);
        tick();
        chk({tag, "_gnt"}, gnt, onehot(ri));
        chk({tag, "_m_start"}, m_start, 1);
        chk({tag, "_m_rw"}, m_rw, rw);
        chk({tag, "_m_addr"}, m_addr, a);
        chk({tag, "_m_wdata"}, m_wdata, wd);
        for (int c = 0; c < dly; c++) begin
            tick();
            chk({tag, "_start_low"}, m_start, 0);
            chk({tag, "_no_early_done"}, done, 0);
        end
        m_done = 1'b1; m_nack = nk; m_rdata = rd;
        tick();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
        check_resp(tag);
        req = '0;
        tick();
        chk({tag, "_gnt_clear"}, gnt, 0);
        chk({tag, "_done_clear"}, done, 0);
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] seen;

        reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_abort", m_abort, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_status", status, 0);
        tick(); tick();
        reset = 1'b1;

        // Master busy holds the arbiter in IDLE.
        m_busy = 1'b1;
        set_req(0, 1'b0, 7'h6B, 8'h33);
        tick();
        chk("busy_hold_gnt", gnt, 0);
        chk("busy_hold_start", m_start, 0);
        m_busy = 1'b0;

        // m_done outside WAIT must be ignored.
        req = '0;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("stray_mdone_done", done, 0);
        chk("stray_mdone_gnt", gnt, 0);

        txn("write", 0, 1'b0, 7'h6B, 8'h33, 10, 1'b0, 8'h00);  // rr -> 1
        txn("read",  2, 1'b1, 7'h21, 8'h00, 3,  1'b0, 8'hA5);  // rr -> 3
        chk("hold_status", status, 2'b00);
        chk("hold_rdata", rdata, 8'hA5);
        txn("nack",  3, 1'b0, 7'h50, 8'h77, 2,  1'b1, 8'hEE);  // rr -> 0
        chk("hold_nack_status", status, 2'b01);

        // Fairness: all four request continuously, master answers at once.
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 7'(7'h10 + i), 8'(8'h11 * i));
        seen = '0;
        for (int n = 0; n < 5; n++) begin
            push_exp(order[n], 2'b00, 8'h00, 1'b0);
            tick();
            chk("rr_gnt", gnt, onehot(order[n]));
            chk("rr_m_addr", m_addr, 7'(7'h10 + order[n]));
            if (n < 4) seen = seen | gnt;
            tick();
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            check_resp("rr");
            tick();
        end
        chk("rr_all_seen", seen, 4'hF);
        req = '0;                                              // rr -> 1

        // Timeout: master never answers; abort must fire in WAIT cycle 16 only.
        set_req(1, 1'b1, 7'h33, 8'h00);
        push_exp(1, 2'b10, 8'h00, 1'b1);
        tick();
        chk("to_m_start", m_start, 1);
        for (int w = 1; w <= 16; w++) begin
            tick();
            chk("to_abort", m_abort, 32'(w == 16));
        end
        tick();
        chk("to_abort_after", m_abort, 0);
        check_resp("to");
        req = '0;
        tick();                                                // rr -> 2

        // m_done and watchdog expiry in the same cycle: m_done wins.
        set_req(2, 1'b1, 7'h44, 8'h00);
        push_exp(2, 2'b00, 8'h5A, 1'b1);
        tick();
        for (int w = 1; w <= 15; w++) tick();
        tick();
        m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h5A;
        #1;
        chk("tie_no_abort", m_abort, 0);
        tick();
        m_done = 1'b0; m_rdata = '0;
        chk("tie_abort_resp", m_abort, 0);
        check_resp("tie");
        req = '0;
        tick();                                                // rr -> 3

        // Reset in WAIT clears outputs immediately and rr_ptr returns to 0.
        set_req(1, 1'b0, 7'h12, 8'h34);
        tick();
        chk("mid_gnt", gnt, onehot(1));
        tick(); tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_done", done, 0);
        chk("arst_m_start", m_start, 0);
        chk("arst_m_abort", m_abort, 0);
        sb.delete();
        req = '0;
        set_req(0, 1'b0, 7'h01, 8'h02);
        set_req(3, 1'b0, 7'h03, 8'h04);
        tick();
        reset = 1'b1;
        push_exp(0, 2'b00, 8'h00, 1'b0);
        tick();
        chk("post_rst_gnt", gnt, onehot(0));
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check_resp("post_rst");
        req = '0;
        tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
